// File: rtl/mux_4_1_rr_arb_if.sv
// mux_4_1_rr_arb_if
// Bundles the request/grant signals between the requesters and the
// round-robin arbiter that drives a shared 4:1 mux.
//   master : requester side  -> drives En, Req0..Req3; sees Gnt*, Sel*, Busy
//   slave  : arbiter side    -> sees En, Req0..Req3; drives Gnt*, Sel*, Busy
interface mux_4_1_rr_arb_if;
    logic En;
    logic Req0, Req1, Req2, Req3;
    logic Gnt0, Gnt1, Gnt2, Gnt3;
    logic Sel1, Sel0;
    logic Busy;

    modport master (
        output En, Req0, Req1, Req2, Req3,
        input  Gnt0, Gnt1, Gnt2, Gnt3, Sel1, Sel0, Busy
    );

    modport slave (
        input  En, Req0, Req1, Req2, Req3,
        output Gnt0, Gnt1, Gnt2, Gnt3, Sel1, Sel0, Busy
    );
endinterface

// File: rtl/mux_4_1_rr_arb.sv
// mux_4_1_rr_arb
// Round-robin arbiter sharing one 4:1 mux between four requesters. Issues a
// registered one-hot grant and the matching registered mux select. A hold
// limit (MAX_HOLD) bounds how long one owner keeps the mux while others wait.
// Ports:
//   Clk    : clock, rising edge
//   Rst_n  : asynchronous active-low reset
//   arb    : slave modport (En, Req0..3 in; Gnt0..3, Sel1/Sel0, Busy out)
module mux_4_1_rr_arb #(
    parameter int MAX_HOLD = 8
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    mux_4_1_rr_arb_if.slave        arb
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] hold_q,  hold_d;

    logic [3:0] req;
    logic [1:0] pick;
    logic       any_req;
    logic       others;
    logic       own_req;

    assign req     = {arb.Req3, arb.Req2, arb.Req1, arb.Req0};
    assign any_req = |req;
    // In GRANT the owner is always last_q, so "others" excludes that index.
    assign others  = |(req & ~(4'b0001 << last_q));
    assign own_req = req[last_q];

    // Search Last+1, Last+2, Last+3, Last. Walking the offsets from far to
    // near lets the nearest requesting index overwrite the result last.
    always_comb begin
        logic [1:0] idx;
        pick = last_q;
        for (int i = 4; i >= 1; i--) begin
            idx = last_q + 2'(i);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (arb.En && any_req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    last_d  = pick;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (!arb.En) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end else if (!own_req) begin
                    if (others) begin
                        gnt_d  = 4'b0001 << pick;
                        sel_d  = pick;
                        last_d = pick;
                        hold_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (hold_q < 8'(MAX_HOLD)) begin
                    hold_d = hold_q + 8'd1;
                end else if (others) begin
                    // Owner is last_q, so pick lands on a different index.
                    gnt_d  = 4'b0001 << pick;
                    sel_d  = pick;
                    last_d = pick;
                    hold_d = 8'd1;
                end
                // Otherwise the owner keeps the mux with hold_q saturated.
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign arb.Gnt0 = gnt_q[0];
    assign arb.Gnt1 = gnt_q[1];
    assign arb.Gnt2 = gnt_q[2];
    assign arb.Gnt3 = gnt_q[3];
    assign arb.Sel1 = sel_q[1];
    assign arb.Sel0 = sel_q[0];
    assign arb.Busy = |gnt_q;

endmodule
